// File: rtl/vec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vec_pkg
// Description : Shared definitions for the vector ALU controller. Holds the
//               controller state encoding, the VSEW element-width codes, the
//               opcode constants and a VSEW legality helper.
// Revision    : 1.0 - initial release
// ============================================================================
package vec_pkg;

    // Controller state encoding
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD1  = 3'd1,
        RD2  = 3'd2,
        RD3  = 3'd3,
        EXEC = 3'd4,
        WB   = 3'd5,
        RESP = 3'd6
    } vec_state_e;

    // Element width codes (element width = 8 << vsew)
    localparam logic [2:0] VSEW_E8  = 3'd0;
    localparam logic [2:0] VSEW_E16 = 3'd1;
    localparam logic [2:0] VSEW_E32 = 3'd2;
    localparam logic [2:0] VSEW_E64 = 3'd3;

    // Opcodes
    localparam logic [5:0] VAND = 6'b001001;

    // Only 8/16/32/64-bit elements are supported
    function automatic logic vsew_legal(input logic [2:0] vsew);
        return (vsew <= VSEW_E64);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vec_tail_merge.sv
`default_nettype none
// ============================================================================
// Module      : vec_tail_merge
// Description : Combinational tail-undisturbed merge. Element i (width
//               8 << vsew bits) of merged comes from new_data when i < vl,
//               otherwise from old_data.
// Ports       : new_data  in  VLEN  ALU result
//               old_data  in  VLEN  previous destination register contents
//               vsew      in  3     element width code
//               vl        in  10    active element count
//               merged    out VLEN  merged write-back data
// Revision    : 1.0 - initial release
// ============================================================================
module vec_tail_merge #(
    parameter logic [9:0] VLEN = 10'd128
) (
    input  logic [VLEN-1:0] new_data,
    input  logic [VLEN-1:0] old_data,
    input  logic [2:0]      vsew,
    input  logic [9:0]      vl,
    output logic [VLEN-1:0] merged
);

    localparam int c_nbytes = int'(VLEN) / 8;

    // Work byte by byte: the byte's element index is its byte index shifted
    // right by vsew, so one comparison against vl covers every element width.
    for (genvar b = 0; b < c_nbytes; b++) begin : g_byte
        localparam logic [9:0] c_b = 10'(b);
        assign merged[8*b +: 8] = ((c_b >> vsew) < vl) ? new_data[8*b +: 8]
                                                        : old_data[8*b +: 8];
    end

endmodule
`default_nettype wire

// File: rtl/vec_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vec_alu_ctrl
// Description : Sequences one vector ALU command: reads vs1, vs2 and the old
//               vd from the register file, runs the external ALU with a
//               timeout, merges the result with the old vd (tail undisturbed)
//               and writes it back, then returns a response.
// Ports       : clk, resetn          clock, asynchronous active-low reset
//               cmd_*                 command handshake and fields
//               rf_*                  register file read (1-cycle latency)
//                                     and write ports
//               alu_*                 external ALU run/done interface
//               rsp_valid/ready/err   response handshake, error flag
// Revision    : 1.0 - initial release
// ============================================================================
module vec_alu_ctrl
    import vec_pkg::*;
#(
    parameter logic [9:0] VLEN    = 10'd128,
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic            clk,
    input  logic            resetn,
    // command
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [5:0]      cmd_opcode,
    input  logic [4:0]      cmd_vs1,
    input  logic [4:0]      cmd_vs2,
    input  logic [4:0]      cmd_vd,
    input  logic [2:0]      cmd_vsew,
    input  logic [9:0]      cmd_vl,
    // register file
    output logic            rf_re,
    output logic [4:0]      rf_raddr,
    input  logic [VLEN-1:0] rf_rdata,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [VLEN-1:0] rf_wdata,
    // ALU
    output logic            alu_run,
    output logic [5:0]      alu_opcode,
    output logic [VLEN-1:0] alu_vs1,
    output logic [VLEN-1:0] alu_vs2,
    output logic [2:0]      alu_vsew,
    input  logic [VLEN-1:0] alu_vd,
    input  logic            alu_done,
    // response
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_err
);

    vec_state_e      r_state;
    vec_state_e      w_next;
    logic            r_out_en;
    logic [5:0]      r_opcode;
    logic [4:0]      r_vs1_idx;
    logic [4:0]      r_vs2_idx;
    logic [4:0]      r_vd_idx;
    logic [2:0]      r_vsew;
    logic [9:0]      r_vl;
    logic            r_err;
    logic [7:0]      r_cnt;
    logic [VLEN-1:0] r_src1;
    logic [VLEN-1:0] r_src2;
    logic [VLEN-1:0] r_old;
    logic [VLEN-1:0] r_result;

    logic            w_accept;
    logic            w_vsew_ok;
    logic [9:0]      w_vlmax;
    logic [9:0]      w_vl_clamp;
    logic            w_timeout;
    logic [VLEN-1:0] w_merged;

    assign w_accept   = cmd_valid && cmd_ready;
    assign w_vsew_ok  = vsew_legal(cmd_vsew);
    // VLMAX = VLEN / element width; only meaningful for legal vsew
    assign w_vlmax    = VLEN >> (cmd_vsew + 3'd3);
    assign w_vl_clamp = (cmd_vl > w_vlmax) ? w_vlmax : cmd_vl;
    // True on the EXEC cycle that completes TIMEOUT cycles of waiting
    assign w_timeout  = (({1'b0, r_cnt} + 9'd1) >= {1'b0, TIMEOUT});

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (!w_vsew_ok || (cmd_vl == 10'd0)) begin
                        w_next = RESP;
                    end else begin
                        w_next = RD1;
                    end
                end
            end
            RD1:  w_next = RD2;
            RD2:  w_next = RD3;
            RD3:  w_next = EXEC;
            EXEC: begin
                if (alu_done) begin
                    w_next = WB;
                end else if (w_timeout) begin
                    w_next = RESP;
                end
            end
            WB:   w_next = RESP;
            RESP: begin
                if (rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out_en  <= 1'b0;
            r_opcode  <= '0;
            r_vs1_idx <= '0;
            r_vs2_idx <= '0;
            r_vd_idx  <= '0;
            r_vsew    <= '0;
            r_vl      <= '0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
            r_src1    <= '0;
            r_src2    <= '0;
            r_old     <= '0;
            r_result  <= '0;
        end else begin
            // Keeps cmd_ready low while reset is held, high once released
            r_out_en <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_opcode  <= cmd_opcode;
                        r_vs1_idx <= cmd_vs1;
                        r_vs2_idx <= cmd_vs2;
                        r_vd_idx  <= cmd_vd;
                        r_vsew    <= cmd_vsew;
                        r_vl      <= w_vl_clamp;
                        r_err     <= !w_vsew_ok;
                        r_cnt     <= '0;
                    end
                end
                // Read data lags rf_re by one cycle: RD2 sees vs1, RD3 sees vs2
                RD2: r_src1 <= rf_rdata;
                RD3: r_src2 <= rf_rdata;
                EXEC: begin
                    // First EXEC cycle carries the old vd read issued in RD3
                    if (r_cnt == 8'd0) begin
                        r_old <= rf_rdata;
                    end
                    r_cnt <= r_cnt + 8'd1;
                    if (alu_done) begin
                        r_result <= alu_vd;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    vec_tail_merge #(
        .VLEN (VLEN)
    ) u_tail_merge (
        .new_data (r_result),
        .old_data (r_old),
        .vsew     (r_vsew),
        .vl       (r_vl),
        .merged   (w_merged)
    );

    // ------------------------------------------------------------------
    // Outputs (decoded from state so reset clears them immediately)
    // ------------------------------------------------------------------
    always_comb begin
        rf_re    = 1'b0;
        rf_raddr = '0;
        case (r_state)
            RD1: begin
                rf_re    = 1'b1;
                rf_raddr = r_vs1_idx;
            end
            RD2: begin
                rf_re    = 1'b1;
                rf_raddr = r_vs2_idx;
            end
            RD3: begin
                rf_re    = 1'b1;
                rf_raddr = r_vd_idx;
            end
            default: ;
        endcase
    end

    assign cmd_ready  = (r_state == IDLE) && r_out_en;
    assign rf_we      = (r_state == WB);
    assign rf_waddr   = rf_we ? r_vd_idx : 5'd0;
    assign rf_wdata   = rf_we ? w_merged : '0;
    assign alu_run    = (r_state == EXEC);
    assign alu_opcode = r_opcode;
    assign alu_vs1    = r_src1;
    assign alu_vs2    = r_src2;
    assign alu_vsew   = r_vsew;
    assign rsp_valid  = (r_state == RESP);
    assign rsp_err    = rsp_valid && r_err;

endmodule
`default_nettype wire

// File: tb/tb_vec_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vec_alu_ctrl
// Description : Directed self-checking bench for vec_alu_ctrl with a register
//               file model and an AND-computing ALU model that can be told
//               never to finish.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_alu_ctrl;
    import vec_pkg::*;

    localparam logic [9:0] c_vlen    = 10'd128;
    localparam logic [7:0] c_timeout = 8'd10;

    logic         clk;
    logic         resetn;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [5:0]   cmd_opcode;
    logic [4:0]   cmd_vs1;
    logic [4:0]   cmd_vs2;
    logic [4:0]   cmd_vd;
    logic [2:0]   cmd_vsew;
    logic [9:0]   cmd_vl;
    logic         rf_re;
    logic [4:0]   rf_raddr;
    logic [127:0] rf_rdata;
    logic         rf_we;
    logic [4:0]   rf_waddr;
    logic [127:0] rf_wdata;
    logic         alu_run;
    logic [5:0]   alu_opcode;
    logic [127:0] alu_vs1;
    logic [127:0] alu_vs2;
    logic [2:0]   alu_vsew;
    logic [127:0] alu_vd;
    logic         alu_done;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_err;

    vec_alu_ctrl #(
        .VLEN    (c_vlen),
        .TIMEOUT (c_timeout)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_vs1    (cmd_vs1),
        .cmd_vs2    (cmd_vs2),
        .cmd_vd     (cmd_vd),
        .cmd_vsew   (cmd_vsew),
        .cmd_vl     (cmd_vl),
        .rf_re      (rf_re),
        .rf_raddr   (rf_raddr),
        .rf_rdata   (rf_rdata),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .alu_run    (alu_run),
        .alu_opcode (alu_opcode),
        .alu_vs1    (alu_vs1),
        .alu_vs2    (alu_vs2),
        .alu_vsew   (alu_vsew),
        .alu_vd     (alu_vd),
        .alu_done   (alu_done),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Register file contents (written only by the stimulus block)
    logic [127:0] regs [32];
    logic         alu_never;

    // Monotonic activity counters kept by the monitor
    int           cnt_re   = 0;
    int           cnt_we   = 0;
    int           cnt_run  = 0;
    int           cnt_both = 0;
    int           alu_cnt  = 0;
    logic [4:0]   last_waddr;
    logic [127:0] last_wdata;
    logic [127:0] last_vs1;
    logic [127:0] last_vs2;
    logic [5:0]   last_op;

    // Read data one cycle after rf_re
    always @(posedge clk) begin
        if (rf_re) rf_rdata <= regs[rf_raddr];
    end

    // Monitor and ALU model, sampled mid-cycle
    always @(negedge clk) begin
        if (rf_re) cnt_re = cnt_re + 1;
        if (rf_re && rf_we) cnt_both = cnt_both + 1;
        if (rf_we) begin
            cnt_we     = cnt_we + 1;
            last_waddr = rf_waddr;
            last_wdata = rf_wdata;
        end
        if (alu_run) begin
            cnt_run  = cnt_run + 1;
            last_vs1 = alu_vs1;
            last_vs2 = alu_vs2;
            last_op  = alu_opcode;
            if (!alu_never && alu_cnt == 2) begin
                alu_done = 1'b1;
                alu_vd   = alu_vs1 & alu_vs2;
            end else begin
                alu_done = 1'b0;
            end
            alu_cnt = alu_cnt + 1;
        end else begin
            alu_cnt  = 0;
            alu_done = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [4:0] vs1, input logic [4:0] vs2, input logic [4:0] vd,
                        input logic [2:0] vsew, input logic [9:0] vl);
        int i;
        for (i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        if (i == 20) check("cmd_ready_wait", 128'd0, 128'd1);
        cmd_opcode = VAND;
        cmd_vs1    = vs1;
        cmd_vs2    = vs2;
        cmd_vd     = vd;
        cmd_vsew   = vsew;
        cmd_vl     = vl;
        cmd_valid  = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int i;
        for (i = 0; i < 100; i++) begin
            if (rsp_valid) break;
            @(negedge clk);
        end
        if (i == 100) check("rsp_wait", 128'd0, 128'd1);
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    int b_re, b_we, b_run;

    initial begin
        resetn     = 1'b0;
        cmd_valid  = 1'b0;
        cmd_opcode = '0;
        cmd_vs1    = '0;
        cmd_vs2    = '0;
        cmd_vd     = '0;
        cmd_vsew   = '0;
        cmd_vl     = '0;
        rsp_ready  = 1'b0;
        alu_never  = 1'b0;
        alu_vd     = '0;
        alu_done   = 1'b0;
        rf_rdata   = '0;
        for (int r = 0; r < 32; r++) regs[r] = '0;
        regs[1] = {4{32'hF0F0F0F0}};
        regs[2] = {4{32'hFF00FF00}};
        regs[4] = {16{8'hAA}};
        regs[5] = 128'h0F0E0D0C0B0A09080706050403020100;
        regs[6] = {16{8'hFF}};
        regs[7] = {16{8'hAA}};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 128'(cmd_ready), 128'd0);
        check("rst_outputs", {123'd0, rf_re, rf_we, alu_run, rsp_valid, rsp_err}, 128'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("rel_cmd_ready", 128'(cmd_ready), 128'd1);

        // VAND, 32-bit elements, all four active
        b_re = cnt_re; b_we = cnt_we;
        send(5'd1, 5'd2, 5'd3, VSEW_E32, 10'd4);
        wait_rsp();
        check("t1_err", 128'(rsp_err), 128'd0);
        check("t1_we_cnt", 128'(cnt_we - b_we), 128'd1);
        check("t1_re_cnt", 128'(cnt_re - b_re), 128'd3);
        check("t1_waddr", 128'(last_waddr), 128'd3);
        check("t1_wdata", last_wdata, {4{32'hF000F000}});
        check("t1_alu_vs1", last_vs1, {4{32'hF0F0F0F0}});
        check("t1_alu_vs2", last_vs2, {4{32'hFF00FF00}});
        check("t1_alu_op", 128'(last_op), 128'(VAND));
        repeat (2) @(negedge clk);
        check("t1_rsp_hold", 128'(rsp_valid), 128'd1);
        finish_rsp();
        check("t1_back_idle", 128'(cmd_ready), 128'd1);

        // Byte elements, vl=5, old vd all AA
        send(5'd5, 5'd6, 5'd4, VSEW_E8, 10'd5);
        wait_rsp();
        check("t2_wdata", last_wdata, {{11{8'hAA}}, 40'h0403020100});
        check("t2_waddr", 128'(last_waddr), 128'd4);
        finish_rsp();

        // Halfword elements, vl=3
        send(5'd5, 5'd6, 5'd4, VSEW_E16, 10'd3);
        wait_rsp();
        check("t3_wdata", last_wdata, {{10{8'hAA}}, 48'h050403020100});
        finish_rsp();

        // vl=0: immediate response, no activity
        b_re = cnt_re; b_we = cnt_we; b_run = cnt_run;
        send(5'd1, 5'd2, 5'd3, VSEW_E8, 10'd0);
        check("t4_rsp_next", 128'(rsp_valid), 128'd1);
        check("t4_err", 128'(rsp_err), 128'd0);
        finish_rsp();
        check("t4_no_act", 128'((cnt_re - b_re) + (cnt_we - b_we) + (cnt_run - b_run)), 128'd0);

        // Illegal vsew
        b_re = cnt_re; b_run = cnt_run;
        send(5'd1, 5'd2, 5'd3, 3'b101, 10'd4);
        wait_rsp();
        check("t5_err", 128'(rsp_err), 128'd1);
        check("t5_no_re", 128'(cnt_re - b_re), 128'd0);
        check("t5_no_run", 128'(cnt_run - b_run), 128'd0);
        finish_rsp();

        // vl=200 at byte width clamps to 16: every byte from the ALU
        send(5'd5, 5'd6, 5'd7, VSEW_E8, 10'd200);
        wait_rsp();
        check("t6_wdata", last_wdata, 128'h0F0E0D0C0B0A09080706050403020100);
        check("t6_err", 128'(rsp_err), 128'd0);
        finish_rsp();

        // Timeout: ALU never finishes
        alu_never = 1'b1;
        b_we = cnt_we; b_run = cnt_run;
        send(5'd1, 5'd2, 5'd3, VSEW_E8, 10'd1);
        wait_rsp();
        check("t7_err", 128'(rsp_err), 128'd1);
        check("t7_run_cycles", 128'(cnt_run - b_run), 128'd10);
        check("t7_no_we", 128'(cnt_we - b_we), 128'd0);
        finish_rsp();

        // Reset during EXEC
        b_we = cnt_we;
        send(5'd1, 5'd2, 5'd3, VSEW_E8, 10'd1);
        begin
            int i;
            for (i = 0; i < 20; i++) begin
                @(negedge clk);
                if (alu_run) break;
            end
            if (i == 20) check("t8_run_wait", 128'd0, 128'd1);
        end
        @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        check("t8_run_drop", 128'(alu_run), 128'd0);
        check("t8_rdy_in_rst", 128'(cmd_ready), 128'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        check("t8_rdy_after", 128'(cmd_ready), 128'd1);
        check("t8_no_we", 128'(cnt_we - b_we), 128'd0);
        alu_never = 1'b0;

        check("never_re_we", 128'(cnt_both), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
